maze_game_logic: RTL and testbench

- Parametrised player-movement and collision engine for the maze game. It sits between the input interface (single-pulse move enables) and the VGA/SSD display path.
- Each accepted move is validated against a synchronous map ROM with configurable read latency.
- Tracks remaining lives, accepted-move count and terminal win/loss states.
- Successor to the fixed 30x21 game-logic block. It adds bounds checking, ROM latency handling, lives, a goal cell and a move counter.

---
 rtl/maze_game_logic.sv | 180 ++++++++++++++++++
 tb/tb_maze_game_logic.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/maze_game_logic.sv
// Player-movement and collision engine for the maze game: validates single-step
// moves against a synchronous map ROM, and tracks lives, the move count and the
// sticky win/loss flags.
module maze_game_logic #(
  parameter int MAP_W   = 30,
  parameter int MAP_H   = 21,
  parameter int POS_W   = 8,
  parameter int START_X = 0,
  parameter int START_Y = 20,
  parameter int GOAL_X  = 29,
  parameter int GOAL_Y  = 0,
  parameter int LIVES   = 3,
  parameter int ROM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 move_en,
  output logic [$clog2(MAP_H)-1:0]   rom_addr,
  input  logic [MAP_W-1:0]           rom_data,
  output logic [POS_W-1:0]           player_x,
  output logic [POS_W-1:0]           player_y,
  output logic [3:0]                 lives,
  output logic [CNT_W-1:0]           move_count,
  output logic                       busy,
  output logic                       lost,
  output logic                       won
);

  localparam int AW = $clog2(MAP_H);
  localparam int WW = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] px_q, px_d, py_q, py_d;
  logic [POS_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [3:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, won_q, won_d, lost_q, lost_d;

  // Candidate position for the highest-priority move bit, with bounds check.
  logic             move_ok;
  logic [POS_W-1:0] next_x, next_y;
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    move_ok = 1'b0;
    next_x  = px_q;
    next_y  = py_q;
    if (move_en[0]) begin
      if (py_q != '0) begin
        move_ok = 1'b1;
        next_y  = py_q - 1'b1;
      end
    end else if (move_en[1]) begin
      if (py_q != POS_W'(MAP_H - 1)) begin
        move_ok = 1'b1;
        next_y  = py_q + 1'b1;
      end
    end else if (move_en[2]) begin
      if (px_q != '0) begin
        move_ok = 1'b1;
        next_x  = px_q - 1'b1;
      end
    end else if (move_en[3]) begin
      if (px_q != POS_W'(MAP_W - 1)) begin
        move_ok = 1'b1;
        next_x  = px_q + 1'b1;
      end
    end
  end

  // Wall bit of the latched candidate column in the returned map row.
  logic [MAP_W-1:0] row_shift;
  logic             wall;
  assign row_shift = rom_data >> cand_x_q;
  assign wall      = row_shift[0];

  // Next-state and datapath updates for the validation FSM.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    rom_addr_d = rom_addr_q;
    wait_d     = wait_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    won_d      = won_q;
    lost_d     = lost_q;
    unique case (state_q)
      IDLE: begin
        if (move_ok) begin
          cand_x_d   = next_x;
          cand_y_d   = next_y;
          rom_addr_d = next_y[AW-1:0];
          busy_d     = 1'b1;
          wait_d     = WW'(ROM_LAT);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WW'(1)) state_d = CHECK;
      end
      CHECK: begin
        busy_d = 1'b0;
        if (!wall) begin
          px_d = cand_x_q;
          py_d = cand_y_q;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (cand_x_q == POS_W'(GOAL_X) && cand_y_q == POS_W'(GOAL_Y)) begin
            won_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          px_d    = POS_W'(START_X);
          py_d    = POS_W'(START_Y);
          lives_d = lives_q - 1'b1;
          if (lives_q == 4'd1) begin
            lost_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight validation.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= IDLE;
      px_q       <= POS_W'(START_X);
      py_q       <= POS_W'(START_Y);
      cand_x_q   <= POS_W'(START_X);
      cand_y_q   <= POS_W'(START_Y);
      rom_addr_q <= AW'(START_Y);
      wait_q     <= '0;
      lives_q    <= 4'(LIVES);
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      rom_addr_q <= rom_addr_d;
      wait_q     <= wait_d;
      lives_q    <= lives_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign player_x   = px_q;
  assign player_y   = py_q;
  assign lives      = lives_q;
  assign move_count = cnt_q;
  assign busy       = busy_q;
  assign won        = won_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_maze_game_logic.sv
// Directed bench: one engine with single-cycle ROM latency, one with three.
module tb_maze_game_logic;

  localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Engine A: ROM_LAT = 1
  logic        rst_a;
  logic [3:0]  mv_a;
  logic [4:0]  rom_addr_a;
  logic [29:0] rom_data_a;
  logic [7:0]  px_a, py_a;
  logic [3:0]  lives_a;
  logic [15:0] cnt_a;
  logic        busy_a, lost_a, won_a;

  // Engine B: ROM_LAT = 3
  logic        rst_b;
  logic [3:0]  mv_b;
  logic [4:0]  rom_addr_b;
  logic [29:0] rom_data_b, rom_b1, rom_b2;
  logic [7:0]  px_b, py_b;
  logic [3:0]  lives_b;
  logic [15:0] cnt_b;
  logic        busy_b, lost_b, won_b;

  maze_game_logic #(.ROM_LAT(1)) u_a (
    .clk(clk), .reset(rst_a), .move_en(mv_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .player_x(px_a), .player_y(py_a), .lives(lives_a), .move_count(cnt_a),
    .busy(busy_a), .lost(lost_a), .won(won_a)
  );

  maze_game_logic #(.ROM_LAT(3)) u_b (
    .clk(clk), .reset(rst_b), .move_en(mv_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .player_x(px_b), .player_y(py_b), .lives(lives_b), .move_count(cnt_b),
    .busy(busy_b), .lost(lost_b), .won(won_b)
  );

  // Map: only wall is row 19, column 1.
  function automatic logic [29:0] map_row(input logic [4:0] row);
    return (row == 5'd19) ? 30'h2 : 30'h0;
  endfunction

  // Synchronous ROM models with 1 and 3 cycles of latency.
  always @(posedge clk) rom_data_a <= map_row(rom_addr_a);
  always @(posedge clk) begin
    rom_b1     <= map_row(rom_addr_b);
    rom_b2     <= rom_b1;
    rom_data_b <= rom_b2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse one move on engine A, then count cycles with busy high (bounded).
  task automatic move_a(input logic [3:0] m, output int bcnt, output logic [4:0] addr0);
    @(negedge clk);
    mv_a = m;
    @(negedge clk);
    mv_a  = '0;
    addr0 = rom_addr_a;
    bcnt  = 0;
    while (busy_a && bcnt < 20) begin
      bcnt++;
      @(negedge clk);
    end
    check("busy_bound_a", 32'(bcnt < 20), 32'd1);
  endtask

  int         bc;
  logic [4:0] ad;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; mv_a = '0; mv_b = '0;
    #1;
    check("rst_px_a", px_a, 32'd0);
    check("rst_py_a", py_a, 32'd20);
    check("rst_lives_a", lives_a, 32'd3);
    check("rst_flags_a", {cnt_a, busy_a, lost_a, won_a}, 32'd0);
    check("rst_addr_a", rom_addr_a, 32'd20);
    check("rst_py_b", py_b, 32'd20);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Right into clear cell (1,20).
    move_a(RIGHT, bc, ad);
    check("right_busy", bc, 32'd2);
    check("right_addr", ad, 32'd20);
    check("right_pos", {px_a, py_a}, {8'd1, 8'd20});
    check("right_cnt", cnt_a, 32'd1);

    // Up into wall at (1,19).
    move_a(UP, bc, ad);
    check("wall_busy", bc, 32'd2);
    check("wall_lives", lives_a, 32'd2);
    check("wall_pos", {px_a, py_a}, {8'd0, 8'd20});
    check("wall_cnt", cnt_a, 32'd1);

    // Out-of-range moves from (0,20) are rejected.
    move_a(LEFT, bc, ad);
    check("left_oob_busy", bc, 32'd0);
    check("left_oob_addr", rom_addr_a, 32'd19);
    move_a(DOWN, bc, ad);
    check("down_oob_busy", bc, 32'd0);
    check("down_oob_addr", rom_addr_a, 32'd19);
    check("oob_pos", {px_a, py_a}, {8'd0, 8'd20});

    // Walk column 0 to the top row, then across to the goal.
    for (int i = 0; i < 20; i++) move_a(UP, bc, ad);
    check("walk_up_pos", {px_a, py_a}, {8'd0, 8'd0});
    check("walk_up_won", won_a, 32'd0);
    for (int i = 0; i < 29; i++) move_a(RIGHT, bc, ad);
    check("goal_pos", {px_a, py_a}, {8'd29, 8'd0});
    check("goal_flags", {won_a, lost_a, busy_a}, 32'b100);
    check("goal_cnt", cnt_a, 32'd50);
    check("goal_lives", lives_a, 32'd2);
    move_a(LEFT, bc, ad);
    check("done_busy", bc, 32'd0);
    check("done_px", px_a, 32'd29);
    check("done_cnt", cnt_a, 32'd50);

    // Reset, then three wall hits exhaust the lives.
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("rst2_state", {px_a, py_a, lives_a, won_a}, {8'd0, 8'd20, 4'd3, 1'b0});
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      move_a(RIGHT, bc, ad);
      move_a(UP, bc, ad);
      check("hit_lives", lives_a, 32'(2 - i));
    end
    check("lost_flags", {lost_a, won_a, busy_a}, 32'b100);
    check("lost_cnt", cnt_a, 32'd3);
    move_a(RIGHT, bc, ad);
    check("lost_busy", bc, 32'd0);
    check("lost_pos", {px_a, py_a, lost_a}, {8'd0, 8'd20, 1'b1});

    // Engine B: up+right together, right again 2 cycles later.
    bc = 0;
    @(negedge clk); mv_b = UP | RIGHT;
    @(negedge clk); mv_b = '0;    if (busy_b) bc++;
    check("b_addr", rom_addr_b, 32'd19);
    @(negedge clk); mv_b = RIGHT; if (busy_b) bc++;
    @(negedge clk); mv_b = '0;    if (busy_b) bc++;
    @(negedge clk);               if (busy_b) bc++;
    @(negedge clk);               if (busy_b) bc++;
    check("b_busy_len", bc, 32'd4);
    repeat (6) @(negedge clk);
    check("b_pos", {px_b, py_b}, {8'd0, 8'd19});
    check("b_cnt", cnt_b, 32'd1);

    // Repeat run aborted by reset during WAIT.
    @(negedge clk); mv_b = UP;
    @(negedge clk); mv_b = '0;
    check("b2_busy", busy_b, 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("b2_rst", {px_b, py_b, lives_b, busy_b}, {8'd0, 8'd20, 4'd3, 1'b0});
    check("b2_cnt", cnt_b, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    repeat (6) @(negedge clk);
    check("b2_after", {px_b, py_b, lives_b, busy_b}, {8'd0, 8'd20, 4'd3, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
